// File: rtl/sdi_gt_bringup_seq_if.sv
// ============================================================================
// Module   : sdi_gt_bringup_seq_if
// Brief    : Control/status bundle between the SDI GT bring-up sequencer and
//            the GT / SDI TX core / LED logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdi_gt_bringup_seq_if;
  logic       i_locked;
  logic       i_qpll_lock;
  logic       i_tx_reset_done;
  logic       i_restart_req;
  logic       o_qpll_reset;
  logic       o_gttx_reset;
  logic       o_tx_userrdy;
  logic       o_sdi_tx_rst;
  logic       o_ready;
  logic       o_fail;
  logic [2:0] o_state;
  logic [3:0] o_retry_cnt;

  // Sequencer side
  modport master (
    input  i_locked, i_qpll_lock, i_tx_reset_done, i_restart_req,
    output o_qpll_reset, o_gttx_reset, o_tx_userrdy, o_sdi_tx_rst,
    output o_ready, o_fail, o_state, o_retry_cnt
  );

  // GT / environment side
  modport slave (
    output i_locked, i_qpll_lock, i_tx_reset_done, i_restart_req,
    input  o_qpll_reset, o_gttx_reset, o_tx_userrdy, o_sdi_tx_rst,
    input  o_ready, o_fail, o_state, o_retry_cnt
  );
endinterface

`default_nettype wire

// File: rtl/sdi_gt_bringup_seq.sv
// ============================================================================
// Module   : sdi_gt_bringup_seq
// Brief    : SDI TX bring-up sequencer: MMCM lock -> QPLL -> GT TX -> SDI core,
//            with timeout retries. Option macro: SDI_SEQ_LOL_RECOVER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdi_gt_bringup_seq #(
  parameter int QPLL_RST_CYCLES = 400,
  parameter int TX_RST_CYCLES   = 400,
  parameter int SDI_RST_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT    = 400000,
  parameter int MAX_RETRIES     = 3
) (
  input  logic                  clk_400_000,
  input  logic                  RESET,
  sdi_gt_bringup_seq_if.master  bus
);

  localparam int MAX_A   = (QPLL_RST_CYCLES > TX_RST_CYCLES) ? QPLL_RST_CYCLES : TX_RST_CYCLES;
  localparam int MAX_B   = (SDI_RST_CYCLES > LOCK_TIMEOUT) ? SDI_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] c_LD_QPLL = TMR_W'(QPLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_LD_TX   = TMR_W'(TX_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_LD_SDI  = TMR_W'(SDI_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_LD_LOCK = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       c_MAX_RTY = 4'(MAX_RETRIES);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_QPLL_RST  = 3'd1;
  localparam logic [2:0] c_QPLL_WAIT = 3'd2;
  localparam logic [2:0] c_TX_RST    = 3'd3;
  localparam logic [2:0] c_TX_WAIT   = 3'd4;
  localparam logic [2:0] c_SDI_RST   = 3'd5;
  localparam logic [2:0] c_RUN       = 3'd6;
  localparam logic [2:0] c_FAIL      = 3'd7;

  logic [1:0]       r_qpll_sync;
  logic [1:0]       r_txdone_sync;
  logic [2:0]       r_state;
  logic [3:0]       r_retry;
  logic [TMR_W-1:0] r_timer;
  logic             r_qpll_reset;
  logic             r_gttx_reset;
  logic             r_tx_userrdy;
  logic             r_sdi_tx_rst;
  logic             r_ready;
  logic             r_fail;

  logic             w_qpll_lock;
  logic             w_tx_done;
  logic             w_tmr_zero;
  logic [2:0]       w_to_state;
  logic [3:0]       w_to_retry;
  logic [3:0]       w_retry_inc;
  logic [2:0]       w_nxt;
  logic [3:0]       w_retry_nxt;
  logic             w_reload;
  logic [TMR_W-1:0] w_timer_nxt;
  logic             w_dec_qpll;
  logic             w_dec_gttx;
  logic             w_dec_usr;
  logic             w_dec_sdi;

  assign w_qpll_lock = r_qpll_sync[1];
  assign w_tx_done   = r_txdone_sync[1];
  assign w_tmr_zero  = (r_timer == '0);
  assign w_retry_inc = (r_retry == c_MAX_RTY) ? r_retry : r_retry + 4'd1;

  // Shared outcome of a lock/resetdone wait that ran out of time
  assign w_to_state  = (r_retry == c_MAX_RTY) ? c_FAIL : c_QPLL_RST;
  assign w_to_retry  = (r_retry == c_MAX_RTY) ? r_retry : r_retry + 4'd1;

  always_comb begin
    w_nxt       = r_state;
    w_retry_nxt = r_retry;
    w_reload    = 1'b0;
    if (!bus.i_locked && (r_state != c_IDLE) && (r_state != c_FAIL)) begin
      w_nxt = c_IDLE;
    end else if (bus.i_restart_req) begin
      w_retry_nxt = 4'd0;
      if (bus.i_locked) begin
        w_nxt    = c_QPLL_RST;
        w_reload = 1'b1;
      end else begin
        w_nxt = c_IDLE;
      end
    end else begin
      case (r_state)
        c_IDLE:      if (bus.i_locked) w_nxt = c_QPLL_RST;
        c_QPLL_RST:  if (w_tmr_zero) w_nxt = c_QPLL_WAIT;
        c_QPLL_WAIT: begin
          if (w_qpll_lock) begin
            w_nxt = c_TX_RST;
          end else if (w_tmr_zero) begin
            w_nxt       = w_to_state;
            w_retry_nxt = w_to_retry;
          end
        end
        c_TX_RST:    if (w_tmr_zero) w_nxt = c_TX_WAIT;
        c_TX_WAIT: begin
          if (!w_qpll_lock) begin
            w_nxt       = c_QPLL_RST;
            w_retry_nxt = w_retry_inc;
          end else if (w_tx_done) begin
            w_nxt = c_SDI_RST;
          end else if (w_tmr_zero) begin
            w_nxt       = w_to_state;
            w_retry_nxt = w_to_retry;
          end
        end
        c_SDI_RST:   if (w_tmr_zero) w_nxt = c_RUN;
        c_RUN: begin
          if (!w_qpll_lock || !w_tx_done) begin
`ifdef SDI_SEQ_LOL_RECOVER_EN
            w_nxt = c_QPLL_RST;
`else
            w_nxt = c_FAIL;
`endif
          end
        end
        c_FAIL:      w_nxt = c_FAIL;
        default:     w_nxt = c_IDLE;
      endcase
      if ((w_nxt == c_RUN) && (r_state != c_RUN)) w_retry_nxt = 4'd0;
    end
  end

  always_comb begin
    w_timer_nxt = r_timer;
    if ((w_nxt != r_state) || w_reload) begin
      case (w_nxt)
        c_QPLL_RST:           w_timer_nxt = c_LD_QPLL;
        c_QPLL_WAIT, c_TX_WAIT: w_timer_nxt = c_LD_LOCK;
        c_TX_RST:             w_timer_nxt = c_LD_TX;
        c_SDI_RST:            w_timer_nxt = c_LD_SDI;
        default:              w_timer_nxt = '0;
      endcase
    end else if (!w_tmr_zero) begin
      w_timer_nxt = r_timer - 1'b1;
    end
  end

  always_comb begin
    w_dec_qpll = 1'b1;
    w_dec_gttx = 1'b1;
    w_dec_usr  = 1'b0;
    w_dec_sdi  = 1'b1;
    case (w_nxt)
      c_QPLL_WAIT: w_dec_qpll = 1'b0;
      c_TX_RST: begin
        w_dec_qpll = 1'b0;
        w_dec_usr  = 1'b1;
      end
      c_TX_WAIT, c_SDI_RST: begin
        w_dec_qpll = 1'b0;
        w_dec_gttx = 1'b0;
        w_dec_usr  = 1'b1;
      end
      c_RUN: begin
        w_dec_qpll = 1'b0;
        w_dec_gttx = 1'b0;
        w_dec_usr  = 1'b1;
        w_dec_sdi  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_400_000 or posedge RESET) begin
    if (RESET) begin
      r_qpll_sync   <= 2'b00;
      r_txdone_sync <= 2'b00;
      r_state       <= c_IDLE;
      r_retry       <= 4'd0;
      r_timer       <= '0;
      r_qpll_reset  <= 1'b1;
      r_gttx_reset  <= 1'b1;
      r_tx_userrdy  <= 1'b0;
      r_sdi_tx_rst  <= 1'b1;
      r_ready       <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_qpll_sync   <= {r_qpll_sync[0], bus.i_qpll_lock};
      r_txdone_sync <= {r_txdone_sync[0], bus.i_tx_reset_done};
      r_state       <= w_nxt;
      r_retry       <= w_retry_nxt;
      r_timer       <= w_timer_nxt;
      r_qpll_reset  <= w_dec_qpll;
      r_gttx_reset  <= w_dec_gttx;
      r_tx_userrdy  <= w_dec_usr;
      r_sdi_tx_rst  <= w_dec_sdi;
      r_ready       <= (w_nxt == c_RUN);
      r_fail        <= (w_nxt == c_FAIL);
    end
  end

  assign bus.o_qpll_reset = r_qpll_reset;
  assign bus.o_gttx_reset = r_gttx_reset;
  assign bus.o_tx_userrdy = r_tx_userrdy;
  assign bus.o_sdi_tx_rst = r_sdi_tx_rst;
  assign bus.o_ready      = r_ready;
  assign bus.o_fail       = r_fail;
  assign bus.o_state      = r_state;
  assign bus.o_retry_cnt  = r_retry;

endmodule

`default_nettype wire

// File: tb/tb_sdi_gt_bringup_seq.sv
// ============================================================================
// Module   : tb_sdi_gt_bringup_seq
// Brief    : Directed bench for sdi_gt_bringup_seq (short timers, MAX_RETRIES=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdi_gt_bringup_seq;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sdi_gt_bringup_seq_if bus_if ();

  sdi_gt_bringup_seq #(
    .QPLL_RST_CYCLES (4),
    .TX_RST_CYCLES   (4),
    .SDI_RST_CYCLES  (8),
    .LOCK_TIMEOUT    (20),
    .MAX_RETRIES     (2)
  ) u_dut (
    .clk_400_000 (clk),
    .RESET       (rst),
    .bus         (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the state is reached; a missed target returns 51 and mismatches
  task automatic wait_state(input logic [2:0] st, input int exp_cyc, input string tag);
    int n;
    n = 0;
    while ((bus_if.o_state != st) && (n <= 50)) begin
      tick();
      n++;
    end
    check(tag, n, exp_cyc);
  endtask

  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, bus_if.o_qpll_reset, bus_if.o_gttx_reset,
                bus_if.o_tx_userrdy, bus_if.o_sdi_tx_rst}, {28'd0, exp});
  endtask

  task automatic restart_pulse();
    bus_if.i_restart_req = 1'b1;
    tick();
    bus_if.i_restart_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.i_locked        = 1'b0;
    bus_if.i_qpll_lock     = 1'b0;
    bus_if.i_tx_reset_done = 1'b0;
    bus_if.i_restart_req   = 1'b0;
    tick();
    tick();
    check("rst_state", {29'd0, bus_if.o_state}, 32'd0);
    check_ctl("rst_ctl", 4'b1101);
    check("rst_ready", {31'd0, bus_if.o_ready}, 32'd0);
    check("rst_fail", {31'd0, bus_if.o_fail}, 32'd0);
    check("rst_retry", {28'd0, bus_if.o_retry_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_hold", {29'd0, bus_if.o_state}, 32'd0);

    // Nominal bring-up
    bus_if.i_locked = 1'b1;
    wait_state(3'd1, 1, "nom_to_qrst");
    check_ctl("nom_qrst_ctl", 4'b1101);
    wait_state(3'd2, 4, "nom_qrst_len");
    check_ctl("nom_qwait_ctl", 4'b0101);
    bus_if.i_qpll_lock = 1'b1;
    wait_state(3'd3, 3, "nom_qwait_len");
    check_ctl("nom_txrst_ctl", 4'b0111);
    wait_state(3'd4, 4, "nom_txrst_len");
    check_ctl("nom_txwait_ctl", 4'b0011);
    bus_if.i_tx_reset_done = 1'b1;
    wait_state(3'd5, 3, "nom_txwait_len");
    check_ctl("nom_sdirst_ctl", 4'b0011);
    wait_state(3'd6, 8, "nom_sdirst_len");
    check_ctl("nom_run_ctl", 4'b0010);
    check("nom_ready", {31'd0, bus_if.o_ready}, 32'd1);
    check("nom_retry", {28'd0, bus_if.o_retry_cnt}, 32'd0);

    // Loss of QPLL lock while running
    bus_if.i_qpll_lock = 1'b0;
`ifdef SDI_SEQ_LOL_RECOVER_EN
    wait_state(3'd1, 3, "lol_to_qrst");
    check("lol_fail", {31'd0, bus_if.o_fail}, 32'd0);
    check("lol_retry", {28'd0, bus_if.o_retry_cnt}, 32'd0);
`else
    wait_state(3'd7, 3, "lol_to_fail");
    check("lol_fail", {31'd0, bus_if.o_fail}, 32'd1);
    check_ctl("lol_ctl", 4'b1101);
`endif
    check("lol_ready", {31'd0, bus_if.o_ready}, 32'd0);

    // QPLL never locks: two retries then FAIL
    bus_if.i_tx_reset_done = 1'b0;
    restart_pulse();
    check("to_restart_state", {29'd0, bus_if.o_state}, 32'd1);
    wait_state(3'd2, 4, "to_qrst0");
    wait_state(3'd1, 20, "to_wait1");
    check("to_retry1", {28'd0, bus_if.o_retry_cnt}, 32'd1);
    wait_state(3'd2, 4, "to_qrst1");
    wait_state(3'd1, 20, "to_wait2");
    check("to_retry2", {28'd0, bus_if.o_retry_cnt}, 32'd2);
    wait_state(3'd2, 4, "to_qrst2");
    wait_state(3'd7, 20, "to_wait3");
    check("to_fail", {31'd0, bus_if.o_fail}, 32'd1);
    check_ctl("to_fail_ctl", 4'b1101);
    check("to_fail_retry", {28'd0, bus_if.o_retry_cnt}, 32'd2);
    tick();
    check("to_fail_sticky", {29'd0, bus_if.o_state}, 32'd7);
    restart_pulse();
    check("to_rs_state", {29'd0, bus_if.o_state}, 32'd1);
    check("to_rs_retry", {28'd0, bus_if.o_retry_cnt}, 32'd0);
    check("to_rs_fail", {31'd0, bus_if.o_fail}, 32'd0);

    // QPLL lock seen exactly on the expiry cycle, then one TX_WAIT timeout
    wait_state(3'd2, 4, "ex_qrst");
    for (int i = 0; i < 17; i++) tick();
    bus_if.i_qpll_lock = 1'b1;
    wait_state(3'd3, 3, "ex_edge");
    check("ex_retry", {28'd0, bus_if.o_retry_cnt}, 32'd0);
    wait_state(3'd4, 4, "tw_txrst");
    wait_state(3'd1, 20, "tw_timeout");
    check("tw_retry1", {28'd0, bus_if.o_retry_cnt}, 32'd1);
    wait_state(3'd2, 4, "tw_qrst");
    wait_state(3'd3, 1, "tw_qwait");
    check("tw_retry_hold", {28'd0, bus_if.o_retry_cnt}, 32'd1);
    wait_state(3'd4, 4, "tw_txrst2");
    bus_if.i_tx_reset_done = 1'b1;
    wait_state(3'd5, 3, "tw_txwait2");
    check("tw_sdi_retry", {28'd0, bus_if.o_retry_cnt}, 32'd1);
    wait_state(3'd6, 8, "tw_run");
    check("tw_run_retry", {28'd0, bus_if.o_retry_cnt}, 32'd0);
    check("tw_ready", {31'd0, bus_if.o_ready}, 32'd1);

    // MMCM lock glitch in TX_WAIT
    bus_if.i_tx_reset_done = 1'b0;
    restart_pulse();
    wait_state(3'd2, 4, "lk_qrst");
    wait_state(3'd3, 1, "lk_qwait");
    wait_state(3'd4, 4, "lk_txrst");
    bus_if.i_locked = 1'b0;
    tick();
    check("lk_idle", {29'd0, bus_if.o_state}, 32'd0);
    check_ctl("lk_idle_ctl", 4'b1101);
    bus_if.i_locked = 1'b1;
    wait_state(3'd1, 1, "lk_relock");
    wait_state(3'd2, 4, "lk_qrst2");
    wait_state(3'd3, 1, "lk_qwait2");
    wait_state(3'd4, 4, "lk_txrst2");
    bus_if.i_tx_reset_done = 1'b1;
    wait_state(3'd5, 3, "lk_txwait2");
    wait_state(3'd6, 8, "lk_run");
    check("lk_ready", {31'd0, bus_if.o_ready}, 32'd1);

    // Asynchronous RESET in the middle of TX_RST
    bus_if.i_tx_reset_done = 1'b0;
    restart_pulse();
    wait_state(3'd2, 4, "ar_qrst");
    wait_state(3'd3, 1, "ar_qwait");
    tick();
    check_ctl("ar_pre_ctl", 4'b0111);
    rst = 1'b1;
    #1;
    check("ar_state", {29'd0, bus_if.o_state}, 32'd0);
    check_ctl("ar_ctl", 4'b1101);
    check("ar_retry", {28'd0, bus_if.o_retry_cnt}, 32'd0);
    #1;
    rst = 1'b0;
    wait_state(3'd1, 1, "ar_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
